hex_scan_driver: RTL

Time-multiplexed driver for a common-anode seven-segment display bank. It accepts hex-digit values from a producer block (for example a counter) through a load strobe. It keeps them in a shadow register and applies them only at frame boundaries, so a frame never shows a mix of old and new digits. It scans one digit per slot and inserts a blanking dead time at the start of every slot to suppress ghosting.

---
 rtl/hex_scan_driver_if.sv | 37 +++
 rtl/hex_scan_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hex_scan_driver_if.sv
// rtl/hex_scan_driver_if.sv - producer/display bundle for the hex scan driver
//
// Purpose: groups the load-side inputs and the display-side outputs of
// hex_scan_driver so that a producer block and the driver share one port.
// Signals:
//   data_i    [4*DIGITS] hex nibbles, nibble k belongs to digit k
//   mask_i    [DIGITS]   per-digit enable, 0 keeps the digit dark
//   dp_i      [DIGITS]   per-digit decimal point request, 1 = lit
//   load_i               one-cycle strobe capturing data_i/mask_i/dp_i
//   pending_o            shadow holds data not yet on the display
//   frame_o              one-cycle pulse after each frame wrap
//   an_o      [DIGITS]   anode selects, active-low
//   seg_o     [7]        segments {g,f,e,d,c,b,a}, active-low
//   dp_o                 decimal point, active-low
interface hex_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_i;
  logic [DIGITS-1:0]   mask_i;
  logic [DIGITS-1:0]   dp_i;
  logic                load_i;
  logic                pending_o;
  logic                frame_o;
  logic [DIGITS-1:0]   an_o;
  logic [6:0]          seg_o;
  logic                dp_o;

  modport master (
    output data_i, mask_i, dp_i, load_i,
    input  pending_o, frame_o, an_o, seg_o, dp_o
  );

  modport slave (
    input  data_i, mask_i, dp_i, load_i,
    output pending_o, frame_o, an_o, seg_o, dp_o
  );
endinterface

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - time-multiplexed common-anode seven-segment driver
//
// Purpose: scans DIGITS hex digits one slot at a time, each slot SCAN_DIV
// cycles long and starting with BLANK_CYCLES of all-anodes-off dead time.
// New values are held in a shadow register and only reach the display at a
// frame wrap, so a frame never mixes old and new digits.
// Ports:
//   clk100_i  system clock
//   rstn_i    synchronous active-low reset
//   bus       hex_scan_driver_if slave modport (load inputs, display outputs)
module hex_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clk100_i,
  input  logic               rstn_i,
  hex_scan_driver_if.slave   bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_sh_data, r_disp_data;
  logic [DIGITS-1:0]     r_sh_mask, r_disp_mask;
  logic [DIGITS-1:0]     r_sh_dp, r_disp_dp;
  logic                  r_pend;
  logic                  r_frame;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tc;
  logic                  w_wrap;
  logic                  w_lit;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;

  assign w_tc   = (r_presc == PW'(SCAN_DIV - 1));
  assign w_wrap = w_tc && (r_idx == IW'(DIGITS - 1));
  // Lit only past the dead time and when the current digit is enabled.
  assign w_lit  = (r_presc >= PW'(BLANK_CYCLES)) && r_disp_mask[r_idx];
  assign w_nib  = r_disp_data[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  // Slot timing: prescaler and digit index.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      if (w_tc) begin
        r_presc <= '0;
        r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Shadow/display hand-over. A load coinciding with the wrap bypasses the
  // shadow so the new values are not held back a whole extra frame.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_sh_data   <= '0;
      r_sh_mask   <= '0;
      r_sh_dp     <= '0;
      r_disp_data <= '0;
      r_disp_mask <= '0;
      r_disp_dp   <= '0;
      r_pend      <= 1'b0;
    end else if (bus.load_i) begin
      r_sh_data <= bus.data_i;
      r_sh_mask <= bus.mask_i;
      r_sh_dp   <= bus.dp_i;
      if (w_wrap) begin
        r_disp_data <= bus.data_i;
        r_disp_mask <= bus.mask_i;
        r_disp_dp   <= bus.dp_i;
        r_pend      <= 1'b0;
      end else begin
        r_pend      <= 1'b1;
      end
    end else if (w_wrap && r_pend) begin
      r_disp_data <= r_sh_data;
      r_disp_mask <= r_sh_mask;
      r_disp_dp   <= r_sh_dp;
      r_pend      <= 1'b0;
    end
  end

  // Pin drive, one cycle behind the slot state.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~r_disp_dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end
  end

  assign bus.pending_o = r_pend;
  assign bus.frame_o   = r_frame;
  assign bus.an_o      = r_an;
  assign bus.seg_o     = r_seg;
  assign bus.dp_o      = r_dp;
endmodule
